uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Sits between the uart receiver and the screen buffer.
- Turns the 4-byte uart frame (column, row, character, line feed) into single-cycle screen-buffer write commands.
- Adds range checks, line-feed resync, an inter-byte timeout and an error pulse, so a dropped byte cannot desynchronise the link permanently.

Parameters:
- N_COL, 80, number of text columns.
- N_ROW, 30, number of text rows.
- TIMEOUT_CYCLES, 250000, idle cycles inside a frame before it is abandoned (10 ms at 25 MHz).
- CLEAR_CHAR, 7'h20, ASCII code written by the clear sweep (optional feature only).

Ports:
- clk_i  in  1  25 MHz pixel/system clock.
- rst_i  in  1  synchronous, active-high reset.
- rx_valid_i  in  1  uart data-valid (wr_o of uart); may stay high for several cycles.
- rx_data_i  in  8  uart received byte.
- wr_en_o  out  1  one-cycle write strobe to the screen buffer.
- col_o  out  7  column to write, 0..N_COL-1.
- row_o  out  5  row to write, 0..N_ROW-1.
- char_o  out  7  ASCII code to write.
- err_o  out  1  one-cycle pulse on a discarded frame or byte.
- busy_o  out  1  clear sweep in progress (constant 0 without the optional feature).

Behaviour:
- **Clock and reset.** One clock domain (clk_i). Reset is synchronous, active-high (rst_i).
  - Outputs at reset: wr_en_o=0, err_o=0, busy_o=0, col_o=0, row_o=0, char_o=0.
  - State returns to S_COL, the timeout counter clears, and the edge-detect register clears.
  - Reset mid-frame or mid-sweep aborts it with no write.
- **Byte accept.** A byte is accepted only in a cycle where rx_valid_i=1 and its registered previous value is 0 (rising edge). Level-held valid produces exactly one accept.
- **S_COL** (accepted byte b):
  - b==8'h0A: consumed silently, stay in S_COL (resync).
  - Otherwise col_reg = (b[6:0]>=N_COL) ? b[6:0]-N_COL : b[6:0], then go to S_ROW.
  - If the result is still >=N_COL (b[6:0]>=160, impossible for N_COL=80), flag an error.
- **S_ROW:**
  - b[4:0]<N_ROW: row_reg=b[4:0], go to S_CHAR.
  - Otherwise set the frame-bad flag and go to S_CHAR. The frame is still consumed so that alignment is kept.
- **S_CHAR:** char_reg=b[6:0], go to S_EOL.
  - Frame good: in the next cycle, wr_en_o=1 with col_o/row_o/char_o valid.
  - Frame bad: in the next cycle, err_o=1 and no write.
- **S_EOL:** b==8'h0A goes to S_COL. Any other byte pulses err_o next cycle and goes to S_COL; the byte is discarded.
- **Write latency.** Exactly one cycle from the accept edge of the char byte to wr_en_o. col_o/row_o/char_o hold their values until the next write.
- **Timeout.**
  - The counter runs in S_ROW, S_CHAR and S_EOL, and clears on every accept.
  - When it reaches TIMEOUT_CYCLES-1, go to S_COL and pulse err_o. No write occurs and the frame-bad flag clears.
  - The counter is idle in S_COL.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- **Simultaneous events.** If an accept and the timeout fall in the same cycle, the accept wins.
- **Output pulses.** wr_en_o and err_o are never high in the same cycle and are never high for 2 consecutive cycles from the same frame.

Optional Feature:
- Macro: UART_CMD_CLEAR_EN.
- **Defined:**
  - Byte 8'h0C accepted in S_COL starts a sweep: busy_o=1 from the next cycle.
  - The sweep issues N_COL*N_ROW consecutive writes (2400), one per cycle, of CLEAR_CHAR. Order is row-major: (col 0,row 0), (1,0) … (79,0), (0,1) … (79,29).
  - busy_o falls in the cycle after the last write.
  - Bytes accepted while busy_o=1 are dropped, each with an err_o pulse in the following cycle.
  - The timeout is inactive during the sweep.
- **Not defined:** 8'h0C in S_COL is an ordinary column byte (col 12); busy_o is tied to 0.

Decomposition:
- Shared package vga_pkg holds:
  - N_COL, N_ROW, N_COL_WIDTH=7, N_ROW_WIDTH=5, N_CHARS_WIDTH=7, UART_DATA_WIDTH=8;
  - ASCII constants LF=8'h0A, FF=8'h0C;
  - the decoder state enum (S_COL, S_ROW, S_CHAR, S_EOL, S_CLEAR).
- One natural sub-module: rx_edge_detect, a registered rising-edge detector on rx_valid_i that is reused wherever uart strobes are consumed.
- Frame FSM, timeout counter and sweep counters stay in uart_cmd_decoder.

Test Plan:
- **Basic frame:** bytes 0x05, 0x03, 0x41, 0x0A, with rx_valid_i held 3 cycles each → exactly one wr_en_o pulse, col_o=5, row_o=3, char_o=0x41, one cycle after the 0x41 edge; err_o stays 0.
- **Column wrap and row range:** frame 0x55,0x1D,0x42,0x0A → col_o=5, row_o=29. Then frame 0x00,0x1E,0x43,0x0A → no write, err_o pulse after the 0x43 byte.
- **Resync:** bytes 0x0A,0x0A, then frame 0x10,0x02,0x30,0x0A → one write (16,2,0x30). Frame with EOL 0x41 instead of 0x0A → write happens, err_o pulses after 0x41, and the next good frame writes correctly.
- **Timeout:** send 0x07,0x01, then idle TIMEOUT_CYCLES (use 100 in the bench) → err_o pulse at count 99. Next bytes 0x02,0x04,0x58,0x0A → write (2,4,0x58).
- **Reset mid-frame:** 0x07,0x01,rst_i 1 cycle,0x09,0x02,0x5A,0x0A → one write (9,2,0x5A); no write containing col 7.
- **UART_CMD_CLEAR_EN:** byte 0x0C → 2400 consecutive wr_en_o cycles of char 0x20 in row-major order, with busy_o high throughout. A byte injected mid-sweep → err_o pulse and no effect. Without the macro, 0x0C,0x00,0x41,0x0A → write (12,0,0x41).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, widths and decoder state encoding for the uart-to-screen-buffer path.
package vga_pkg;

  localparam int N_COL           = 80;
  localparam int N_ROW           = 30;
  localparam int N_COL_WIDTH     = 7;
  localparam int N_ROW_WIDTH     = 5;
  localparam int N_CHARS_WIDTH   = 7;
  localparam int UART_DATA_WIDTH = 8;

  localparam logic [UART_DATA_WIDTH-1:0] LF = 8'h0A;
  localparam logic [UART_DATA_WIDTH-1:0] FF = 8'h0C;

  typedef enum logic [2:0] {
    S_COL,
    S_ROW,
    S_CHAR,
    S_EOL,
    S_CLEAR
  } dec_state_e;

endpackage

// File: rtl/rx_edge_detect.sv
// Registered rising-edge detector for uart data-valid strobes that may be held high for several cycles.
module rx_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic rise_o
);

  logic valid_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_p1 <= 1'b0;
    end else begin
      valid_p1 <= valid_i;
    end
  end

  assign rise_o = valid_i & ~valid_p1;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes 4-byte uart frames (col, row, char, LF) into single-cycle screen-buffer writes.
// Optional full-screen clear sweep on a form-feed byte when UART_CMD_CLEAR_EN is defined.
module uart_cmd_decoder #(
  parameter int         N_COL          = 80,
  parameter int         N_ROW          = 30,
  parameter int         TIMEOUT_CYCLES = 250000,
  parameter logic [6:0] CLEAR_CHAR     = 7'h20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       wr_en_o,
  output logic [6:0] col_o,
  output logic [4:0] row_o,
  output logic [6:0] char_o,
  output logic       err_o,
  output logic       busy_o
);
  import vga_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [N_COL_WIDTH-1:0] COL_LIM  = N_COL_WIDTH'(N_COL);
  localparam logic [N_ROW_WIDTH-1:0] ROW_LIM  = N_ROW_WIDTH'(N_ROW);
  localparam logic [N_COL_WIDTH-1:0] COL_LAST = N_COL_WIDTH'(N_COL - 1);
  localparam logic [N_ROW_WIDTH-1:0] ROW_LAST = N_ROW_WIDTH'(N_ROW - 1);
  localparam logic [TO_W-1:0]        TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  // A single subtraction folds column codes N_COL..2*N_COL-1 back into range.
  function automatic logic [N_COL_WIDTH-1:0] wrap_col(input logic [N_COL_WIDTH-1:0] b);
    return (b >= COL_LIM) ? b - COL_LIM : b;
  endfunction

  logic                        accept;
  logic                        take;
  dec_state_e                  state_q, state_d;
  logic [N_COL_WIDTH-1:0]      col_q, col_d;
  logic [N_ROW_WIDTH-1:0]      row_q, row_d;
  logic                        bad_q, bad_d;
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
  logic                        in_frame;
  logic                        wr_d, err_d;
  logic [N_COL_WIDTH-1:0]      wcol_d, wrapped;
  logic [N_ROW_WIDTH-1:0]      wrow_d;
  logic [N_CHARS_WIDTH-1:0]    wchar_d;

`ifdef UART_CMD_CLEAR_EN
  logic [N_COL_WIDTH-1:0]      clr_col_q, clr_col_d;
  logic [N_ROW_WIDTH-1:0]      clr_row_q, clr_row_d;
  logic                        busy_q, busy_d;
`endif

  rx_edge_detect u_rx_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (rx_valid_i),
    .rise_o  (accept)
  );

  assign in_frame = (state_q == S_ROW) || (state_q == S_CHAR) || (state_q == S_EOL);
  assign wrapped  = wrap_col(rx_data_i[6:0]);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    bad_d    = bad_q;
    to_cnt_d = in_frame ? to_cnt_q + TO_W'(1) : '0;
    wr_d     = 1'b0;
    err_d    = 1'b0;
    wcol_d   = col_o;
    wrow_d   = row_o;
    wchar_d  = char_o;
    take     = accept;
`ifdef UART_CMD_CLEAR_EN
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    busy_d    = 1'b0;
    // Any byte arriving while busy is visible is dropped and reported.
    if (busy_q && accept) begin
      take  = 1'b0;
      err_d = 1'b1;
    end
    if (state_q == S_CLEAR) begin
      wr_d    = 1'b1;
      wcol_d  = clr_col_q;
      wrow_d  = clr_row_q;
      wchar_d = CLEAR_CHAR;
      if (clr_col_q == COL_LAST) begin
        clr_col_d = '0;
        if (clr_row_q == ROW_LAST) begin
          clr_row_d = '0;
          state_d   = S_COL;
        end else begin
          clr_row_d = clr_row_q + N_ROW_WIDTH'(1);
        end
      end else begin
        clr_col_d = clr_col_q + N_COL_WIDTH'(1);
      end
    end
`endif
    if (take) begin
      to_cnt_d = '0;
      case (state_q)
        S_COL: begin
          if (rx_data_i == LF) begin
            state_d = S_COL;
          end
`ifdef UART_CMD_CLEAR_EN
          else if (rx_data_i == FF) begin
            clr_col_d = '0;
            clr_row_d = '0;
            state_d   = S_CLEAR;
          end
`endif
          else begin
            col_d   = wrapped;
            bad_d   = (wrapped >= COL_LIM);
            state_d = S_ROW;
          end
        end
        S_ROW: begin
          if (rx_data_i[4:0] < ROW_LIM) begin
            row_d = rx_data_i[4:0];
          end else begin
            bad_d = 1'b1;
          end
          state_d = S_CHAR;
        end
        S_CHAR: begin
          if (bad_q) begin
            err_d = 1'b1;
          end else begin
            wr_d    = 1'b1;
            wcol_d  = col_q;
            wrow_d  = row_q;
            wchar_d = rx_data_i[6:0];
          end
          bad_d   = 1'b0;
          state_d = S_EOL;
        end
        S_EOL: begin
          err_d   = (rx_data_i != LF);
          state_d = S_COL;
        end
        default: state_d = S_COL;
      endcase
    end else if (in_frame && (to_cnt_q == TO_LAST)) begin
      // Abandon a stalled frame so the next byte is treated as a column again.
      state_d  = S_COL;
      err_d    = 1'b1;
      bad_d    = 1'b0;
      to_cnt_d = '0;
    end
`ifdef UART_CMD_CLEAR_EN
    // Held through the cycle carrying the final sweep write.
    busy_d = (state_d == S_CLEAR) || (state_q == S_CLEAR);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_COL;
      to_cnt_q <= '0;
      bad_q    <= 1'b0;
      wr_en_o  <= 1'b0;
      err_o    <= 1'b0;
      col_o    <= '0;
      row_o    <= '0;
      char_o   <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      bad_q    <= bad_d;
      wr_en_o  <= wr_d;
      err_o    <= err_d;
      col_o    <= wcol_d;
      row_o    <= wrow_d;
      char_o   <= wchar_d;
    end
  end

  always_ff @(posedge clk_i) begin
    col_q <= col_d;
    row_q <= row_d;
  end

`ifdef UART_CMD_CLEAR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_col_q <= '0;
      clr_row_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o = busy_q;
`else
  assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: expected writes/errors are queued with their due cycle.
module tb_uart_cmd_decoder;

  localparam int TO = 100;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       wr_en_o;
  logic [6:0] col_o;
  logic [4:0] row_o;
  logic [6:0] char_o;
  logic       err_o;
  logic       busy_o;

  uart_cmd_decoder #(
    .N_COL          (80),
    .N_ROW          (30),
    .TIMEOUT_CYCLES (TO),
    .CLEAR_CHAR     (7'h20)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .wr_en_o    (wr_en_o),
    .col_o      (col_o),
    .row_o      (row_o),
    .char_o     (char_o),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  always #20 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int due;
    int col;
    int row;
    int ch;
    bit sweep;
  } wr_t;

  wr_t wr_q[$];
  int  err_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of its queue at the due cycle.
  always @(negedge clk_i) begin
    if (err_o) begin
      if (err_q.size() == 0) begin
        chk("err_unexpected", 1, 0);
      end else begin
        int d;
        d = err_q.pop_front();
        chk("err_cycle", cyc, d);
      end
    end
    if (wr_en_o) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected_col", int'(col_o), -1);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_cycle", cyc, e.due);
        chk("wr_col", int'(col_o), e.col);
        chk("wr_row", int'(row_o), e.row);
        chk("wr_char", int'(char_o), e.ch);
        if (e.sweep) chk("busy_in_sweep", int'(busy_o), 1);
      end
    end
    if (wr_en_o && err_o && !busy_o) chk("wr_err_overlap", 1, 0);
  end

  task automatic byte_on(input logic [7:0] b);
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
  endtask

  task automatic byte_off();
    repeat (3) @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_on(b);
    byte_off();
  endtask

  // Reference model of one frame: column wrap, row range, EOL check.
  task automatic frame(input logic [7:0] c, input logic [7:0] r,
                       input logic [7:0] ch, input logic [7:0] eol);
    int col;
    int row;
    bit bad;
    col = int'(c[6:0]);
    if (col >= 80) col = col - 80;
    row = int'(r[4:0]);
    bad = (col >= 80) || (row >= 30);
    send(c);
    send(r);
    byte_on(ch);
    if (bad) err_q.push_back(cyc + 1);
    else     wr_q.push_back('{cyc + 1, col, row, int'(ch[6:0]), 1'b0});
    byte_off();
    byte_on(eol);
    if (eol != 8'h0A) err_q.push_back(cyc + 1);
    byte_off();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((wr_q.size() != 0) || (err_q.size() != 0)) && (n < 4000)) begin
      @(negedge clk_i);
      n++;
    end
    repeat (6) @(negedge clk_i);
    chk("drain_wr", wr_q.size(), 0);
    chk("drain_err", err_q.size(), 0);
    wr_q.delete();
    err_q.delete();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    chk("rst_wr", int'(wr_en_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_col", int'(col_o), 0);
    chk("rst_row", int'(row_o), 0);
    chk("rst_char", int'(char_o), 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Basic frame
    frame(8'h05, 8'h03, 8'h41, 8'h0A);
    drain();

    // Column wrap, then row out of range
    frame(8'h55, 8'h1D, 8'h42, 8'h0A);
    frame(8'h00, 8'h1E, 8'h43, 8'h0A);
    drain();

    // Resync on stray LFs, bad EOL, recovery
    send(8'h0A);
    send(8'h0A);
    frame(8'h10, 8'h02, 8'h30, 8'h0A);
    frame(8'h11, 8'h04, 8'h41, 8'h41);
    frame(8'h12, 8'h05, 8'h44, 8'h0A);
    drain();

    // Inter-byte timeout
    send(8'h07);
    byte_on(8'h01);
    err_q.push_back(cyc + 1 + TO);
    byte_off();
    drain();
    frame(8'h02, 8'h04, 8'h58, 8'h0A);
    drain();

    // Reset mid-frame
    send(8'h07);
    send(8'h01);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst_col", int'(col_o), 0);
    chk("midrst_char", int'(char_o), 0);
    frame(8'h09, 8'h02, 8'h5A, 8'h0A);
    drain();

`ifdef UART_CMD_CLEAR_EN
    // Clear sweep with a byte injected halfway
    byte_on(8'h0C);
    for (int k = 0; k < 2400; k++) begin
      wr_q.push_back('{cyc + 2 + k, k % 80, k / 80, 32'h20, 1'b1});
    end
    byte_off();
    repeat (500) @(negedge clk_i);
    chk("sweep_busy_mid", int'(busy_o), 1);
    byte_on(8'h33);
    err_q.push_back(cyc + 1);
    byte_off();
    drain();
    chk("sweep_busy_end", int'(busy_o), 0);
    frame(8'h03, 8'h01, 8'h45, 8'h0A);
    drain();
`else
    // Form feed is an ordinary column byte
    frame(8'h0C, 8'h00, 8'h41, 8'h0A);
    drain();
    chk("busy_tied", int'(busy_o), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
